serial_ip_accum: RTL and testbench



---
 rtl/serial_ip_accum.sv | 167 ++++++++++++++++
 tb/tb_serial_ip_accum.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_ip_accum.sv
// serial_ip_accum: bit-serial inner-product stage fed by a bit-plane transposer.
// Drives the transposer's bit-select MSB-first. Each returned plane gates the
// latched signed weights, and an adder tree reduces them. The plane sums are
// shift-accumulated into one signed dot product, which is handed downstream
// on a valid/ready handshake.
// Optional build macro: SERIAL_IP_SIGNED_ACT_EN. When it is defined,
// activations are two's complement and the MSB plane is subtracted.
module serial_ip_accum #(
  parameter int WORDS    = 16,
  parameter int WL       = 16,
  parameter int SEL_BITS = 4,
  parameter int ACC_WL   = 36
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WORDS*WL-1:0]    weights,
  input  logic [SEL_BITS:0]      prec,
  output logic [SEL_BITS:0]      sel,
  input  logic [WORDS-1:0]       stream,
  output logic                   busy,
  output logic [ACC_WL-1:0]      result,
  output logic                   result_valid,
  input  logic                   result_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [SEL_BITS:0] WL_SEL  = (SEL_BITS+1)'(WL);
  localparam logic [SEL_BITS:0] SEL_ONE = (SEL_BITS+1)'(1);

  state_e                state_q, state_d;
  logic [SEL_BITS:0]     sel_q, sel_d;
  logic [WORDS*WL-1:0]   weights_q, weights_d;
  logic [ACC_WL-1:0]     acc_q, acc_d;
  logic [ACC_WL-1:0]     result_q, result_d;
  logic                  result_valid_q, result_valid_d;
  // High when stream carries a plane requested during the previous RUN cycle.
  logic                  plane_valid_q, plane_valid_d;
`ifdef SERIAL_IP_SIGNED_ACT_EN
  // High until the first (sign) plane of the current operand has been folded in.
  logic                  msb_pending_q, msb_pending_d;
`endif

  logic [ACC_WL-1:0]     partial;
  logic [ACC_WL-1:0]     acc_next;
  logic [SEL_BITS:0]     prec_eff;

  // A precision of 0 or one wider than the word means full word length.
  assign prec_eff = (prec == '0 || prec > WL_SEL) ? WL_SEL : prec;

  // Adder tree: sum of sign-extended weights whose activation bit is set.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    partial = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (stream[i]) begin
        partial = partial + ACC_WL'($signed(weights_q[i*WL +: WL]));
      end
    end
  end

  // Shift-accumulate step (MSB-first). The sign plane is subtracted in the signed build.
  always_comb begin
    acc_next = (acc_q << 1) + partial;
`ifdef SERIAL_IP_SIGNED_ACT_EN
    if (msb_pending_q) begin
      acc_next = '0 - partial;
    end
`endif
  end

  // Next-state and datapath update for the IDLE/RUN/DRAIN/DONE sequence.
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    weights_d      = weights_q;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    plane_valid_d  = (state_q == RUN);
`ifdef SERIAL_IP_SIGNED_ACT_EN
    msb_pending_d  = msb_pending_q;
`endif

    if (plane_valid_q) begin
      acc_d = acc_next;
`ifdef SERIAL_IP_SIGNED_ACT_EN
      msb_pending_d = 1'b0;
`endif
    end

    unique case (state_q)
      IDLE: begin
        sel_d = '0;
        if (start) begin
          weights_d = weights;
          acc_d     = '0;
          sel_d     = prec_eff - SEL_ONE;
          state_d   = RUN;
`ifdef SERIAL_IP_SIGNED_ACT_EN
          msb_pending_d = 1'b1;
`endif
        end
      end
      RUN: begin
        if (sel_q == '0) begin
          state_d = DRAIN;
        end else begin
          sel_d = sel_q - SEL_ONE;
        end
      end
      DRAIN: begin
        sel_d          = '0;
        result_d       = acc_next;
        result_valid_d = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        sel_d = '0;
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      // NOTE: the weight register is a wide storage array but is still reset,
      // so a post-reset result never depends on stale operands.
      weights_q      <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      plane_valid_q  <= 1'b0;
`ifdef SERIAL_IP_SIGNED_ACT_EN
      msb_pending_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values; blocking here would create ordering-dependent races.
      state_q        <= state_d;
      sel_q          <= sel_d;
      weights_q      <= weights_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      plane_valid_q  <= plane_valid_d;
`ifdef SERIAL_IP_SIGNED_ACT_EN
      msb_pending_q  <= msb_pending_d;
`endif
    end
  end

  assign sel          = sel_q;
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_serial_ip_accum.sv
// Directed bench for serial_ip_accum. A registered transposer model returns
// the plane for the previous sel. A queue scoreboard holds the dot product
// expected for each accepted start.
module tb_serial_ip_accum;

  localparam int WORDS    = 16;
  localparam int WL       = 16;
  localparam int SEL_BITS = 4;
  localparam int ACC_WL   = 36;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [WORDS*WL-1:0]  weights;
  logic [SEL_BITS:0]    prec;
  logic [SEL_BITS:0]    sel;
  logic [WORDS-1:0]     stream;
  logic                 busy;
  logic [ACC_WL-1:0]    result;
  logic                 result_valid;
  logic                 result_ready;

  logic [WL-1:0]        act [WORDS];
  logic [ACC_WL-1:0]    exp_q [$];
  int                   checks   = 0;
  int                   failures = 0;

  serial_ip_accum #(
    .WORDS(WORDS), .WL(WL), .SEL_BITS(SEL_BITS), .ACC_WL(ACC_WL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .weights(weights), .prec(prec),
    .sel(sel), .stream(stream), .busy(busy), .result(result),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  // Registered transposer: plane for the sel seen at this edge appears next cycle.
  always @(posedge clk) begin : transposer_model
    for (int i = 0; i < WORDS; i++) begin
      stream[i] <= (int'(sel) < WL) ? act[i][sel[SEL_BITS-1:0]] : 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  // Reference dot product from whole-word multiplies on P-bit activations.
  function automatic logic [ACC_WL-1:0] model_dot(input int p);
    longint sum;
    longint a;
    longint w;
    sum = 0;
    for (int i = 0; i < WORDS; i++) begin
      a = longint'(act[i]) & ((longint'(1) << p) - 1);
`ifdef SERIAL_IP_SIGNED_ACT_EN
      if (a[p-1]) a = a - (longint'(1) << p);
`endif
      w = longint'($signed(weights[i*WL +: WL]));
      sum = sum + w * a;
    end
    return sum[ACC_WL-1:0];
  endfunction

  task automatic clear_operands();
    weights = '0;
    for (int i = 0; i < WORDS; i++) act[i] = '0;
  endtask

  task automatic load_s1();
    clear_operands();
    weights[0*WL +: WL] = 16'd1;
    weights[1*WL +: WL] = 16'd2;
    weights[2*WL +: WL] = 16'd3;
    weights[3*WL +: WL] = 16'd4;
    act[0] = 16'h3;
    act[1] = 16'hA;
    act[2] = 16'hE;
    act[3] = 16'hF;
  endtask

  // One full operation, called just after a falling edge with the DUT idle.
  // stall=1 holds result_ready low for 5 cycles and pulses start in DONE.
  task automatic do_op(input logic [SEL_BITS:0] p_in, input bit stall);
    int p_eff;
    logic [ACC_WL-1:0] exp_r;
    p_eff = (p_in == 0 || int'(p_in) > WL) ? WL : int'(p_in);
    exp_q.push_back(model_dot(p_eff));
    prec         = p_in;
    start        = 1'b1;
    result_ready = !stall;
    @(negedge clk);
    // Operands must have been latched: scramble the live inputs.
    start = 1'b0;
    for (int i = 0; i < WORDS*WL/32; i++) weights[i*32 +: 32] = $urandom;
    prec = (SEL_BITS+1)'($urandom);
    check("busy_run", busy, 1);
    for (int k = p_eff - 1; k >= 0; k--) begin
      check($sformatf("sel_p%0d_k%0d", p_eff, k), sel, 64'(k));
      @(negedge clk);
    end
    check("valid_low_drain", result_valid, 0);
    @(negedge clk);
    check($sformatf("valid_rise_p%0d", p_eff), result_valid, 1);
    exp_r = exp_q.pop_front();
    check($sformatf("result_p%0d", p_eff), result, exp_r);
    if (stall) begin
      for (int c = 0; c < 5; c++) begin
        start = (c % 2 == 0);
        @(negedge clk);
        check("hold_valid", result_valid, 1);
        check("hold_result", result, exp_r);
      end
      start        = 1'b0;
      result_ready = 1'b1;
    end
    @(negedge clk);
    check("valid_drop", result_valid, 0);
    check("busy_idle", busy, 0);
    check("sel_idle", sel, 0);
    check("result_kept", result, exp_r);
    result_ready = 1'b0;
  endtask

  initial begin
    logic [ACC_WL-1:0] signed_exp;
    rst_n = 1'b0;
    start = 1'b0;
    result_ready = 1'b0;
    prec = '0;
    clear_operands();
    #12;
    check("rst_busy", busy, 0);
    check("rst_sel", sel, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic dot product: 125 (unsigned activations).
    load_s1();
    do_op(4, 1'b0);

    // Negative weight -1 against activation 0xF.
    clear_operands();
    weights[0 +: WL] = 16'hFFFF;
    act[0] = 16'hF;
    do_op(4, 1'b0);

    // Full precision via prec=0 and prec=17.
    clear_operands();
    weights[0 +: WL] = 16'd1;
    act[0] = 16'hFFFF;
    do_op(0, 1'b0);
    clear_operands();
    weights[0 +: WL] = 16'd1;
    act[0] = 16'hFFFF;
    do_op(17, 1'b0);

    // Backpressure, then an immediately following operation.
    load_s1();
    do_op(4, 1'b1);
    load_s1();
    do_op(4, 1'b0);

    // Asynchronous reset while sel=2.
    load_s1();
    prec  = 4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_sel", sel, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sel", sel, 0);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_s1();
    do_op(4, 1'b0);

    // Activation signedness: w0=1, act0=0xF.
    clear_operands();
    weights[0 +: WL] = 16'd1;
    act[0] = 16'hF;
    do_op(4, 1'b0);
`ifdef SERIAL_IP_SIGNED_ACT_EN
    signed_exp = '1;
`else
    signed_exp = 36'd15;
`endif
    check("signed_act_const", result, signed_exp);

    // A few random operands and precisions.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < WORDS*WL/32; i++) weights[i*32 +: 32] = $urandom;
      for (int i = 0; i < WORDS; i++) act[i] = 16'($urandom);
      do_op((SEL_BITS+1)'($urandom_range(1, WL)), r == 1);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
